axi_slv_mem: RTL and testbench

//  Parametrised AXI4 slave memory. Serves as the responder behind the slave interface and as the DUT-side model in the TB.

---
 rtl/axi_slv_pkg.sv | 66 ++++++
 rtl/axi_slv_addr_gen.sv | 39 +++
 rtl/axi_slv_mem.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi_slv_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI4 slave memory (axi_slv_mem).
// Burst/response encodings, FSM state types and the burst legality check.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // A burst is legal when its size fits the bus, its type is not reserved and,
  // for WRAP, its length is 2/4/8/16 beats with a start address aligned to size.
  // Only the low address byte matters for the alignment check.
  function automatic logic legal_burst(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] addr_lo,
                                       input logic [2:0] max_size);
    logic       ok;
    logic [7:0] mask;
    ok   = 1'b1;
    mask = (8'd1 << size) - 8'd1;
    if (size > max_size) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    case (burst)
      BURST_RSVD: ok = 1'b0;
      BURST_WRAP: begin
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
        if ((addr_lo & mask) != 8'd0) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
      end
      default: ok = ok;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Next-beat address generator for one AXI burst path (FIXED/INCR/WRAP).
// Purely combinational; the caller registers the result.
module axi_slv_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] bytes_s;
  logic [ADDR_WIDTH-1:0] incr_s;
  logic [ADDR_WIDTH-1:0] span_s;
  logic [ADDR_WIDTH-1:0] mask_s;
  logic [ADDR_WIDTH-1:0] wrap_s;

  // Step the address by the transfer size; WRAP folds back inside the aligned window.
  always_comb begin
    bytes_s   = ONE << size;
    incr_s    = addr + bytes_s;
    span_s    = bytes_s * ({{(ADDR_WIDTH-8){1'b0}}, len} + ONE);
    mask_s    = span_s - ONE;
    wrap_s    = (addr & ~mask_s) | (incr_s & mask_s);
    next_addr = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP:  next_addr = wrap_s;
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) FSMs over one
// word-addressed array. Optional build macro AXI_SLV_MEM_RANGE_CHK_EN turns
// word indices >= MEM_DEPTH into per-beat SLVERR instead of wrapping modulo depth.
module axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         ADDR_LSB = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // ---------------- write path ----------------
  wr_state_e             wr_state_r, wr_state_s;
  logic [ID_WIDTH-1:0]   bid_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r, wr_next_addr_s;
  logic [7:0]            wr_len_r, wr_beat_r;
  logic [2:0]            wr_size_r;
  logic [1:0]            wr_burst_r, bresp_r;
  logic                  wr_bad_r, wr_err_r;
  logic                  awready_r, wready_r, bvalid_r;
  logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, w_mismatch_s;
  logic                  w_oor_s, w_we_s, aw_legal_s;
  logic [IDX_W-1:0]      w_idx_s;

  axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr_gen (
    .addr      (wr_addr_r),
    .len       (wr_len_r),
    .size      (wr_size_r),
    .burst     (wr_burst_r),
    .next_addr (wr_next_addr_s)
  );

`ifdef AXI_SLV_MEM_RANGE_CHK_EN
  assign w_oor_s = |(wr_addr_r >> (ADDR_LSB + IDX_W));
`else
  assign w_oor_s = 1'b0;
`endif

  // Write handshakes, beat bookkeeping and the write-side next state.
  always_comb begin
    aw_hs_s       = awvalid && awready_r;
    w_hs_s        = wvalid && wready_r;
    b_hs_s        = bvalid_r && bready;
    w_last_beat_s = (wr_beat_r == wr_len_r);
    w_mismatch_s  = w_hs_s && (wlast != w_last_beat_s);
    w_we_s        = w_hs_s && !wr_bad_r && !w_oor_s;
    w_idx_s       = wr_addr_r[ADDR_LSB +: IDX_W];
    aw_legal_s    = legal_burst(awlen, awsize, awburst, awaddr[7:0], MAX_SIZE);
    wr_state_s    = wr_state_r;
    case (wr_state_r)
      W_IDLE: if (aw_hs_s) wr_state_s = W_DATA; else wr_state_s = W_IDLE;
      W_DATA: if (w_hs_s && w_last_beat_s) wr_state_s = W_RESP; else wr_state_s = W_DATA;
      W_RESP: if (b_hs_s) wr_state_s = W_IDLE; else wr_state_s = W_RESP;
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Write FSM state, registered handshake outputs and captured burst attributes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bid_r      <= {ID_WIDTH{1'b0}};
      bresp_r    <= 2'b00;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_len_r   <= 8'd0;
      wr_beat_r  <= 8'd0;
      wr_size_r  <= 3'd0;
      wr_burst_r <= 2'b00;
      wr_bad_r   <= 1'b0;
      wr_err_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_s;
      awready_r  <= (wr_state_s == W_IDLE);
      wready_r   <= (wr_state_s == W_DATA);
      bvalid_r   <= (wr_state_s == W_RESP);
      if (aw_hs_s) begin
        bid_r      <= awid;
        wr_addr_r  <= awaddr;
        wr_len_r   <= awlen;
        wr_size_r  <= awsize;
        wr_burst_r <= awburst;
        wr_beat_r  <= 8'd0;
        wr_bad_r   <= !aw_legal_s;
        wr_err_r   <= !aw_legal_s;
      end else if (w_hs_s) begin
        wr_addr_r <= wr_next_addr_s;
        wr_beat_r <= wr_beat_r + 8'd1;
        wr_err_r  <= wr_err_r | w_mismatch_s | w_oor_s;
        if (w_last_beat_s) begin
          bresp_r <= (wr_err_r | w_mismatch_s | w_oor_s) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-strobed array write; the array itself is never reset.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (w_we_s && wstrb[b]) begin
        mem_r[w_idx_s][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e             rd_state_r, rd_state_s;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r, rd_next_addr_s, f_addr_s;
  logic [7:0]            rd_len_r, rd_beat_r;
  logic [2:0]            rd_size_r;
  logic [1:0]            rd_burst_r, rresp_r;
  logic                  rd_bad_r, arready_r, rvalid_r, rlast_r;
  logic                  ar_hs_s, r_hs_s, r_last_beat_s, rd_load_s;
  logic                  f_bad_s, f_last_s, f_oor_s;
  logic [IDX_W-1:0]      f_idx_s;

  axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr_gen (
    .addr      (rd_addr_r),
    .len       (rd_len_r),
    .size      (rd_size_r),
    .burst     (rd_burst_r),
    .next_addr (rd_next_addr_s)
  );

`ifdef AXI_SLV_MEM_RANGE_CHK_EN
  assign f_oor_s = |(f_addr_s >> (ADDR_LSB + IDX_W));
`else
  assign f_oor_s = 1'b0;
`endif

  // Pick the beat to fetch next (first beat straight from AR) and the read next state.
  always_comb begin
    ar_hs_s       = arvalid && arready_r;
    r_hs_s        = rvalid_r && rready;
    r_last_beat_s = (rd_beat_r == rd_len_r);
    rd_load_s     = ar_hs_s || (r_hs_s && !r_last_beat_s);
    if (ar_hs_s) begin
      f_addr_s = araddr;
      f_bad_s  = !legal_burst(arlen, arsize, arburst, araddr[7:0], MAX_SIZE);
      f_last_s = (arlen == 8'd0);
    end else begin
      f_addr_s = rd_next_addr_s;
      f_bad_s  = rd_bad_r;
      f_last_s = ((rd_beat_r + 8'd1) == rd_len_r);
    end
    f_idx_s    = f_addr_s[ADDR_LSB +: IDX_W];
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: if (ar_hs_s) rd_state_s = R_DATA; else rd_state_s = R_IDLE;
      R_DATA: if (r_hs_s && r_last_beat_s) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Read FSM state and the R beat register, which only moves when a new beat is loaded.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rid_r      <= {ID_WIDTH{1'b0}};
      rdata_r    <= {DATA_WIDTH{1'b0}};
      rresp_r    <= 2'b00;
      rlast_r    <= 1'b0;
      rd_addr_r  <= {ADDR_WIDTH{1'b0}};
      rd_len_r   <= 8'd0;
      rd_beat_r  <= 8'd0;
      rd_size_r  <= 3'd0;
      rd_burst_r <= 2'b00;
      rd_bad_r   <= 1'b0;
    end else begin
      rd_state_r <= rd_state_s;
      arready_r  <= (rd_state_s == R_IDLE);
      rvalid_r   <= (rd_state_s == R_DATA);
      if (ar_hs_s) begin
        rid_r      <= arid;
        rd_len_r   <= arlen;
        rd_size_r  <= arsize;
        rd_burst_r <= arburst;
        rd_beat_r  <= 8'd0;
        rd_bad_r   <= f_bad_s;
      end else if (rd_load_s) begin
        rd_beat_r <= rd_beat_r + 8'd1;
      end
      if (rd_load_s) begin
        rd_addr_r <= f_addr_s;
        rdata_r   <= (f_bad_s || f_oor_s) ? {DATA_WIDTH{1'b0}} : mem_r[f_idx_s];
        rresp_r   <= (f_bad_s || f_oor_s) ? RESP_SLVERR : RESP_OKAY;
        rlast_r   <= f_last_s;
      end
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rid     = rid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed self-checking bench for axi_slv_mem (default 32-bit configuration).
// Follows AXI_SLV_MEM_RANGE_CHK_EN to pick the expected out-of-range behaviour.
module tb_axi_slv_mem;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  awid = 8'd0, arid = 8'd0;
  logic [31:0] awaddr = 32'd0, araddr = 32'd0;
  logic [7:0]  awlen = 8'd0, arlen = 8'd0;
  logic [2:0]  awsize = 3'd0, arsize = 3'd0;
  logic [1:0]  awburst = 2'd0, arburst = 2'd0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic        awready, arready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] exp_d [16];
  logic [7:0]  g_bid, g_bid2;
  logic [1:0]  g_bresp, g_bresp2;

  always #5 aclk = ~aclk;

  axi_slv_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                           output logic [7:0] o_bid, output logic [1:0] o_bresp);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) check("aw_timeout", 64'd0, 64'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      n = 0;
      while (wready !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) check("w_timeout", 64'd0, 64'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) check("b_timeout", 64'd0, 64'd1);
    o_bid = bid; o_bresp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] exp_resp, input int stall_beat);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) check("ar_timeout", 64'd0, 64'd1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        rready = 1'b0;
        repeat (5) begin
          check("stall_rvalid", 64'(rvalid), 64'd1);
          check("stall_rdata", 64'(rdata), 64'(exp_d[i]));
          check("stall_rlast", 64'(rlast), 64'(i == int'(len)));
          tick();
        end
      end
      rready = 1'b1;
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) check("r_timeout", 64'd0, 64'd1);
      check("rdata", 64'(rdata), 64'(exp_d[i]));
      check("rresp", 64'(rresp), 64'(exp_resp));
      check("rlast", 64'(rlast), 64'(i == int'(len)));
      check("rid", 64'(rid), 64'(id));
      tick();
    end
    rready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin wd[i] = 32'd0; ws[i] = 4'hF; exp_d[i] = 32'd0; end
    // reset values
    repeat (3) tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    areset = 1'b0;
    tick();
    check("rel_awready", 64'(awready), 64'd1);
    check("rel_arready", 64'(arready), 64'd1);

    // INCR len=3 at 0x10
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); exp_d[i] = 32'hA0 + 32'(i); end
    axi_write(8'h5A, 32'h10, 8'd3, 3'd2, 2'b01, -1, g_bid, g_bresp);
    check("incr_bresp", 64'(g_bresp), 64'd0);
    check("incr_bid", 64'(g_bid), 64'h5A);
    axi_read(8'h33, 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, -1);

    // WRAP len=3 at 0x08: beats land at 0x08,0x0C,0x00,0x04
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
    axi_write(8'h01, 32'h08, 8'd3, 3'd2, 2'b10, -1, g_bid, g_bresp);
    check("wrap_bresp", 64'(g_bresp), 64'd0);
    exp_d[0] = 32'hB2; exp_d[1] = 32'hB3; exp_d[2] = 32'hB0; exp_d[3] = 32'hB1;
    axi_read(8'h02, 32'h00, 8'd3, 3'd2, 2'b01, 2'b00, -1);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hB0 + 32'(i);
    axi_read(8'h03, 32'h08, 8'd3, 3'd2, 2'b10, 2'b00, -1);

    // WRAP len=2 is illegal: SLVERR, memory untouched, read returns zeros
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
    axi_write(8'h04, 32'h10, 8'd2, 3'd2, 2'b10, -1, g_bid, g_bresp);
    check("wrap2_bresp", 64'(g_bresp), 64'd2);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    axi_read(8'h05, 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, -1);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'd0;
    axi_read(8'h06, 32'h10, 8'd2, 3'd2, 2'b10, 2'b10, -1);

    // byte strobes 0101 over a zeroed word
    wd[0] = 32'd0; ws[0] = 4'hF;
    axi_write(8'h07, 32'h40, 8'd0, 3'd2, 2'b01, -1, g_bid, g_bresp);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
    axi_write(8'h08, 32'h40, 8'd0, 3'd2, 2'b01, -1, g_bid, g_bresp);
    ws[0] = 4'hF;
    exp_d[0] = 32'h00FF_00FF;
    axi_read(8'h09, 32'h40, 8'd0, 3'd2, 2'b01, 2'b00, -1);

    // early wlast on beat 1 of len=3: all 4 beats taken, SLVERR
    for (int i = 0; i < 4; i++) wd[i] = 32'hD0 + 32'(i);
    axi_write(8'h0A, 32'h80, 8'd3, 3'd2, 2'b01, 1, g_bid, g_bresp);
    check("wlast_bresp", 64'(g_bresp), 64'd2);
    check("wlast_bid", 64'(g_bid), 64'h0A);

    // oversize transfer is illegal: SLVERR and no write
    wd[0] = 32'hDEAD_BEEF;
    axi_write(8'h0B, 32'h10, 8'd0, 3'd3, 2'b01, -1, g_bid, g_bresp);
    check("size_bresp", 64'(g_bresp), 64'd2);
    exp_d[0] = 32'hA0;
    axi_read(8'h0C, 32'h10, 8'd0, 3'd2, 2'b01, 2'b00, -1);

    // reserved burst type on read: zeros with SLVERR on every beat
    exp_d[0] = 32'd0; exp_d[1] = 32'd0;
    axi_read(8'h0D, 32'h10, 8'd1, 3'd2, 2'b11, 2'b10, -1);

    // FIXED burst keeps hitting one word
    wd[0] = 32'hF0; wd[1] = 32'hF1;
    axi_write(8'h0E, 32'h300, 8'd1, 3'd2, 2'b00, -1, g_bid, g_bresp);
    check("fixed_bresp", 64'(g_bresp), 64'd0);
    exp_d[0] = 32'hF1;
    axi_read(8'h0F, 32'h300, 8'd0, 3'd2, 2'b01, 2'b00, -1);

    // rready stalled for 5 cycles on beat 1
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    axi_read(8'h10, 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, 1);

    // concurrent write and read bursts
    for (int i = 0; i < 4; i++) wd[i] = 32'hE0 + 32'(i);
    fork
      axi_write(8'h21, 32'h200, 8'd3, 3'd2, 2'b01, -1, g_bid2, g_bresp2);
      axi_read(8'h22, 32'h10, 8'd3, 3'd2, 2'b01, 2'b00, -1);
    join
    check("conc_bresp", 64'(g_bresp2), 64'd0);
    check("conc_bid", 64'(g_bid2), 64'h21);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hE0 + 32'(i);
    axi_read(8'h23, 32'h200, 8'd3, 3'd2, 2'b01, 2'b00, -1);

    // reset during beat 2 of a len=7 write
    for (int i = 0; i < 8; i++) wd[i] = 32'h1111_0000 + 32'(i);
    awid = 8'h30; awaddr = 32'h100; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = 4'hF; wlast = 1'b0;
      check("rst_burst_wready", 64'(wready), 64'd1);
      tick();
    end
    wdata = wd[2];
    areset = 1'b1;
    #1;
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    tick();
    areset = 1'b0; wvalid = 1'b0;
    tick();
    check("postrst_awready", 64'(awready), 64'd1);
    check("postrst_bvalid", 64'(bvalid), 64'd0);
    check("postrst_wready", 64'(wready), 64'd0);
    exp_d[0] = 32'h1111_0000; exp_d[1] = 32'h1111_0001;
    axi_read(8'h31, 32'h100, 8'd1, 3'd2, 2'b01, 2'b00, -1);

    // address one word past the array
    wd[0] = 32'h1234_5678;
    axi_write(8'h40, 32'h1000, 8'd0, 3'd2, 2'b01, -1, g_bid, g_bresp);
`ifdef AXI_SLV_MEM_RANGE_CHK_EN
    check("oor_bresp", 64'(g_bresp), 64'd2);
    exp_d[0] = 32'd0;
    axi_read(8'h41, 32'h1000, 8'd0, 3'd2, 2'b01, 2'b10, -1);
`else
    check("mod_bresp", 64'(g_bresp), 64'd0);
    exp_d[0] = 32'h1234_5678;
    axi_read(8'h41, 32'h0, 8'd0, 3'd2, 2'b01, 2'b00, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
